// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs req/ack with instruction memory, hands words to decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of silently aligning them.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        fetch_misalign
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FLUSH,
        HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pend, pend_n;
    logic [31:0] instr_n, pcout_n;
    logic        jump;
    logic [31:0] jump_tgt;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        pend_n   = pend;
        instr_n  = instruction;
        pcout_n  = pc_out;
        jump     = 1'b0;
        jump_tgt = redirect_pc;

        case (state)
            IDLE: state_n = FETCH;

            FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        jump = 1'b1;
                    end else begin
                        pend_n  = redirect_pc;
                        state_n = FLUSH;
                    end
                end else if (imem_ack) begin
                    instr_n = imem_rdata;
                    pcout_n = pc;
                    state_n = HOLD;
                end
            end

            // Wrong-path request still outstanding; the newest target wins.
            FLUSH: begin
                if (imem_ack) begin
                    jump = 1'b1;
                    if (!redirect_valid) jump_tgt = pend;
                end else if (redirect_valid) begin
                    pend_n = redirect_pc;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    jump = 1'b1;
                end else if (instr_ready) begin
                    pc_n    = pc + 32'd4;
                    state_n = FETCH;
                end
            end

`ifdef FETCH_MISALIGN_TRAP_EN
            TRAP: begin
                if (redirect_valid) jump = 1'b1;
            end
`endif

            default: state_n = IDLE;
        endcase

        if (jump) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (jump_tgt[1:0] != 2'b00) begin
                state_n = TRAP;
                pcout_n = jump_tgt;
            end else begin
                pc_n    = word_align(jump_tgt);
                state_n = FETCH;
            end
`else
            pc_n    = word_align(jump_tgt);
            state_n = FETCH;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            pc_out      <= RESET_PC;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instruction <= instr_n;
            pc_out      <= pcout_n;
        end
    end

    // Pending target is only read after being written in FETCH, so it needs no reset.
    always_ff @(posedge clk) begin
        pend <= pend_n;
    end

    assign imem_req    = (state == FETCH) || (state == FLUSH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = (state == TRAP);
`else
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// program-order model (expected PC stream and address-derived memory contents).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        fetch_misalign;

    int tests;
    int fails;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instruction(instruction), .pc_out(pc_out),
        .fetch_misalign(fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    // Leaves the DUT in FETCH at address a with nothing outstanding.
    task automatic goto_fetch(input logic [31:0] a);
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = a; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            imem_ack = $urandom_range(0, 1) == 1; imem_rdata = $urandom;
            instr_ready = $urandom_range(0, 1) == 1;
            redirect_valid = $urandom_range(0, 1) == 1; redirect_pc = $urandom;
            tick();
        end
        rst = 1'b1; tick();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        tests++; if (instruction !== NOP_INSTR) begin fails++; $display("FAIL reset_instr: got %h want %h", instruction, NOP_INSTR); end
        tests++; if (pc_out !== RESET_PC) begin fails++; $display("FAIL reset_pc_out: got %h want %h", pc_out, RESET_PC); end
        tests++; if (fetch_misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b want 0", fetch_misalign); end
        rst = 1'b0; idle_inputs();
        tick();
        tests++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin fails++; $display("FAIL first_req: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    endtask

    // Synchronous memory: sees the request at an edge and acks in the next cycle.
    task automatic test_zero_wait();
        int          vcyc[$];
        logic [31:0] vpc[$];
        logic        pending;
        do_reset();
        imem_rdata = 32'h0020_80B3; instr_ready = 1'b1; pending = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (instr_valid) begin
                vcyc.push_back(c); vpc.push_back(pc_out);
                tests++; if (instruction !== 32'h0020_80B3) begin fails++; $display("FAIL zw_instr: got %h want 002080b3", instruction); end
            end
            imem_ack = imem_req && pending;
            pending  = imem_req && !imem_ack;
            tick();
        end
        idle_inputs();
        tests++; if (vcyc.size() !== 3) begin fails++; $display("FAIL zw_count: got %0d want 3", vcyc.size()); end
        if (vcyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (vpc[i] !== 32'(4 * i)) begin fails++; $display("FAIL zw_pc%0d: got %h want %h", i, vpc[i], 32'(4 * i)); end
            end
            tests++; if (vcyc[1] - vcyc[0] != 3 || vcyc[2] - vcyc[1] != 3) begin fails++; $display("FAIL zw_spacing: got %0d,%0d want 3,3", vcyc[1] - vcyc[0], vcyc[2] - vcyc[1]); end
        end
    endtask

    task automatic test_ack_delay();
        goto_fetch(32'h10);
        for (int i = 0; i < 4; i++) begin
            tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin fails++; $display("FAIL delay_addr%0d: got %b/%h want 1/00000010", i, imem_req, imem_addr); end
            imem_ack = (i == 3); imem_rdata = (i == 3) ? 32'hCAFE_0113 : $urandom;
            tick();
        end
        idle_inputs();
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL delay_valid: got %b want 1", instr_valid); end
        tests++; if (instruction !== 32'hCAFE_0113) begin fails++; $display("FAIL delay_instr: got %h want cafe0113", instruction); end
        tests++; if (pc_out !== 32'h10) begin fails++; $display("FAIL delay_pc_out: got %h want 00000010", pc_out); end
    endtask

    // Continues from the HOLD state left by test_ack_delay.
    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
            tick();
            tests++; if ({instr_valid, imem_req, instruction, pc_out} !== {1'b1, 1'b0, 32'hCAFE_0113, 32'h10}) begin
                fails++; $display("FAIL stall%0d: got v=%b r=%b %h@%h want v=1 r=0 cafe0113@00000010", i, instr_valid, imem_req, instruction, pc_out);
            end
        end
        idle_inputs(); instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tests++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h14, 1'b0}) begin fails++; $display("FAIL stall_next: got r=%b %h v=%b want r=1 00000014 v=0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_redirect_flush();
        goto_fetch(32'h40);
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h800;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin fails++; $display("FAIL flush_wait%0d: got v=%b r=%b %h want v=0 r=1 00000040", i, instr_valid, imem_req, imem_addr); end
            imem_ack = (i == 1); imem_rdata = 32'hBAD0_0013;
            tick();
        end
        imem_ack = 1'b0;
        tests++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h800}) begin fails++; $display("FAIL flush_target: got v=%b r=%b %h want v=0 r=1 00000800", instr_valid, imem_req, imem_addr); end
        instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h00A0_0093;
        tick();
        imem_ack = 1'b0;
        tests++; if ({instr_valid, instruction, pc_out} !== {1'b1, 32'h00A0_0093, 32'h800}) begin fails++; $display("FAIL flush_result: got v=%b %h@%h want v=1 00a00093@00000800", instr_valid, instruction, pc_out); end
    endtask

    task automatic test_wrap_and_reset();
        goto_fetch(32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        tests++; if ({instr_valid, pc_out} !== {1'b1, 32'hFFFF_FFFC}) begin fails++; $display("FAIL wrap_hold: got v=%b %h want v=1 fffffffc", instr_valid, pc_out); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL wrap_addr: got r=%b %h want r=1 00000000", imem_req, imem_addr); end
        goto_fetch(32'h300);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin fails++; $display("FAIL flush_pre_rst: got r=%b %h want r=1 00000300", imem_req, imem_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({imem_req, imem_addr, instr_valid} !== {1'b0, RESET_PC, 1'b0}) begin fails++; $display("FAIL rst_in_flush: got r=%b %h v=%b want r=0 %h v=0", imem_req, imem_addr, instr_valid, RESET_PC); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tests++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin fails++; $display("FAIL rst_refetch: got r=%b %h want r=1 %h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_misalign();
        goto_fetch(32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h802; instr_ready = 1'b1;
        tick();
        idle_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
        tests++; if ({fetch_misalign, pc_out, imem_req, instr_valid} !== {1'b1, 32'h802, 1'b0, 1'b0}) begin fails++; $display("FAIL trap_enter: got m=%b %h r=%b v=%b want m=1 00000802 r=0 v=0", fetch_misalign, pc_out, imem_req, instr_valid); end
        imem_ack = 1'b1; instr_ready = 1'b1;
        tick();
        idle_inputs();
        tests++; if ({fetch_misalign, imem_req} !== {1'b1, 1'b0}) begin fails++; $display("FAIL trap_stay: got m=%b r=%b want m=1 r=0", fetch_misalign, imem_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h900;
        tick();
        idle_inputs();
        tests++; if ({fetch_misalign, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h900}) begin fails++; $display("FAIL trap_exit: got m=%b r=%b %h want m=0 r=1 00000900", fetch_misalign, imem_req, imem_addr); end
        goto_fetch(32'h100);
        redirect_valid = 1'b1; redirect_pc = 32'h806;
        tick();
        idle_inputs();
        tests++; if ({fetch_misalign, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin fails++; $display("FAIL trap_via_flush: got m=%b r=%b %h want m=0 r=1 00000100", fetch_misalign, imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
        idle_inputs();
        tests++; if ({fetch_misalign, pc_out, imem_req} !== {1'b1, 32'h806, 1'b0}) begin fails++; $display("FAIL trap_after_flush: got m=%b %h r=%b want m=1 00000806 r=0", fetch_misalign, pc_out, imem_req); end
`else
        tests++; if ({fetch_misalign, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h800}) begin fails++; $display("FAIL misalign_masked: got m=%b r=%b %h want m=0 r=1 00000800", fetch_misalign, imem_req, imem_addr); end
`endif
    endtask

    // Model: the decoder must see an unbroken program-order stream starting at the latest
    // redirect target, each word equal to the memory contents at its address.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_req, prev_ack;
        int          wait_left;
        int          accepted;
        do_reset();
        exp_pc = RESET_PC; wait_left = -1; accepted = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (imem_req && prev_req && !prev_ack && imem_addr !== prev_addr) begin
                tests++; fails++; $display("FAIL rnd_addr_stable c%0d: got %h want %h", c, imem_addr, prev_addr);
            end
            if (imem_req) begin
                tests++; if (imem_addr[1:0] !== 2'b00) begin fails++; $display("FAIL rnd_align c%0d: got %h want low bits 00", c, imem_addr); end
            end
            if (instr_valid) begin
                tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rnd_req_in_hold c%0d: got 1 want 0", c); end
                tests++; if (pc_out !== exp_pc) begin fails++; $display("FAIL rnd_pc c%0d: got %h want %h", c, pc_out, exp_pc); end
                tests++; if (instruction !== memf(exp_pc)) begin fails++; $display("FAIL rnd_instr c%0d: got %h want %h", c, instruction, memf(exp_pc)); end
            end
            if (imem_req) begin
                if (wait_left < 0) wait_left = $urandom_range(0, 3);
                imem_ack = (wait_left == 0);
                wait_left = imem_ack ? -1 : wait_left - 1;
            end else begin
                imem_ack = $urandom_range(0, 7) == 0;
                wait_left = -1;
            end
            imem_rdata = (imem_ack && imem_req) ? memf(imem_addr) : $urandom;
            instr_ready = $urandom_range(0, 2) != 0;
            redirect_valid = (c > 2) && ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | redirect_pc[3:0];
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (instr_valid && instr_ready) begin exp_pc = exp_pc + 32'd4; accepted++; end
            prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
            tick();
        end
        idle_inputs();
        tests++; if (accepted < 100) begin fails++; $display("FAIL rnd_progress: got %0d accepted want >= 100", accepted); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_hold_stall();
        test_redirect_flush();
        test_wrap_and_reset();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
